// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, drives the synchronous-read imem,
// and hands (pc, inst) pairs to decode over valid/ready with a one-entry hold buffer.
module inst_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_misaligned
);

  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_req_q, pc_req_d;
  logic [ADDR_WIDTH-1:0]   pc_resp_q, pc_resp_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   hold_inst_q, hold_inst_d;
  logic [ADDR_WIDTH-1:0]   hold_pc_q, hold_pc_d;

  // imem_addr depends only on registered state and redirect, never on out_ready.
  assign imem_addr = redirect_valid ? redirect_pc : pc_req_q;

  always_comb begin
    out_inst = imem_inst;
    out_pc   = pc_resp_q;
    if (state_q == HOLD) begin
      out_inst = hold_inst_q;
      out_pc   = hold_pc_q;
    end
  end

  assign out_valid      = ((state_q == HOLD) || resp_valid_q) && !redirect_valid;
  assign out_misaligned = |out_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_req_d     = pc_req_q;
    pc_resp_d    = pc_resp_q;
    resp_valid_d = resp_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;

    if (redirect_valid) begin
      state_d      = RUN;
      pc_resp_d    = redirect_pc;
      pc_req_d     = redirect_pc + PC_STEP;
      resp_valid_d = 1'b1;
      hold_inst_d  = '0;
      hold_pc_d    = '0;
    end else if (state_q == RUN) begin
      if (!resp_valid_q || out_ready) begin
        pc_resp_d    = pc_req_q;
        pc_req_d     = pc_req_q + PC_STEP;
        resp_valid_d = 1'b1;
      end else begin
        state_d     = HOLD;
        hold_inst_d = imem_inst;
        hold_pc_d   = pc_resp_q;
      end
    end else if (out_ready) begin
      // pc_req was re-presented this cycle, so its data lands next cycle; the
      // register steps past it so the following fetch is not a duplicate.
      state_d      = RUN;
      pc_resp_d    = pc_req_q;
      pc_req_d     = pc_req_q + PC_STEP;
      resp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_req_q     <= RESET_PC;
      pc_resp_q    <= '0;
      resp_valid_q <= 1'b0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_req_q     <= pc_req_d;
      pc_resp_q    <= pc_resp_d;
      resp_valid_q <= resp_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule
